// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- iterative multiply/divide sequencer with architectural HI/LO.
//
// Executes mult/multu/div/divu over a fixed 34-cycle schedule
// (PREP 1 + CALC 32 + FIX 1), followed by a one-cycle DONE. One shared
// 33-bit add/subtract path serves both the shift-add multiply and the
// restoring divide. HI/LO are written only at the end of FIX, or by
// mthi/mtlo while idle.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          launch; sampled only in IDLE (busy=0, done=0)
//   op             00 mult, 01 multu, 10 div, 11 divu
//   srcA, srcB     multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we   mthi/mtlo write enables (IDLE only, start has priority)
//   wdata          mthi/mtlo data
//   busy           operation in progress (PREP/CALC/FIX)
//   done           one-cycle pulse, HI/LO already hold the new result
//   div_by_zero    pulses with done when a divide had srcB=0
//   hi, lo         HI/LO registers
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;          // raw latched operands
    logic [WIDTH-1:0]   m_q;               // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   acc_hi, acc_lo;    // {P_hi,P_lo} or {R,Q}
    logic [4:0]         cnt_q;
    logic               neg_q;             // product / quotient must be negated
    logic               rem_neg_q;         // remainder must be negated
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operation decode from the latched opcode.
    logic is_div, is_signed;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    // ------------------------------------------------------------------
    // Shared 33-bit add/subtract path.
    //   multiply: {0,P_hi} + (P_lo[0] ? {0,M} : 0)
    //   divide:   {R,Q[31]} - {0,D}
    // For divide the true difference lies in [-D, D-1], which always fits
    // a 33-bit signed value, so bit 32 is a reliable "negative" flag.
    // ------------------------------------------------------------------
    logic [WIDTH:0] alu_x, alu_y, alu_sum;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned -- that is what keeps latches from appearing.
        alu_x = {1'b0, acc_hi};
        alu_y = '0;
        if (is_div) begin
            alu_x = {acc_hi, acc_lo[WIDTH-1]};
            alu_y = ~{1'b0, m_q};
        end else if (acc_lo[0]) begin
            alu_y = {1'b0, m_q};
        end
        alu_sum = alu_x + alu_y + {{WIDTH{1'b0}}, is_div};
    end

    // Operand magnitudes for PREP (0x8000_0000 stays 0x8000_0000, which is
    // the correct unsigned magnitude).
    logic [WIDTH-1:0] mag_a, mag_b;
    assign mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Signed fixup applied in FIX.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               b_zero;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix  = rem_neg_q ? -acc_hi : acc_hi;
    assign b_zero   = (b_q == '0);

    // ------------------------------------------------------------------
    // FSM: state register + next-state/output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        div_by_zero = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_PREP;
            S_PREP: begin
                busy    = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                div_by_zero = is_div && b_zero;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement
            // order within this block.
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= srcA;
                        b_q  <= srcB;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_PREP: begin
                    acc_hi    <= '0;
                    m_q       <= is_div ? mag_b : mag_a;
                    acc_lo    <= is_div ? mag_a : mag_b;
                    neg_q     <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_neg_q <= is_signed && is_div && a_q[WIDTH-1];
                    cnt_q     <= 5'd31;
                end
                S_CALC: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (!is_div) begin
                        // Shift the accumulator right, carry-out enters P_hi.
                        acc_hi <= alu_sum[WIDTH:1];
                        acc_lo <= {alu_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (!alu_sum[WIDTH]) begin
                        acc_hi <= alu_sum[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        // Restore: keep the shifted remainder.
                        acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi_q <= a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// -----------------------------------------------------------------------------
// tb_mdu_seq -- directed self-checking bench for mdu_seq.
// Hand-computed vectors for each operation type, signed corner cases,
// divide by zero, busy protection, mthi/mtlo and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mdu_seq;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA, srcB;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .srcA        (srcA),
        .srcB        (srcB),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to completion.
    //   disturb       : pulse start/hi_we/lo_we and change operands mid-CALC
    //   start_in_done : hold start high during the DONE cycle (must be ignored)
    //   lo_with_start : assert lo_we together with start (write must be dropped)
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz, input bit disturb,
                          input bit start_in_done, input bit lo_with_start,
                          input logic [31:0] lo_before);
        int  busy_cnt;
        bit  seen;
        bit  overlap;
        busy_cnt = 0;
        seen     = 0;
        overlap  = 0;
        @(negedge clk);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        if (lo_with_start) begin
            lo_we = 1'b1;
            wdata = 32'h0000_0055;
        end
        @(posedge clk);  // E0
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        srcA  = $urandom;
        srcB  = $urandom;
        if (lo_with_start) check({tag, " lo kept on start"}, lo, lo_before);
        for (int c = 0; c < 60; c++) begin
            if (busy && done) overlap = 1;
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
            if (disturb && c == 10) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
                op    = OP_DIVU;
                srcA  = 32'h1111_1111;
                srcB  = 32'h0000_0003;
            end else if (disturb && c == 11) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'd34);
        check({tag, " busy&done overlap"}, 64'(overlap), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
        if (start_in_done) begin
            op    = OP_MULTU;
            srcA  = 32'h0000_0002;
            srcB  = 32'h0000_0002;
            start = 1'b1;
        end
        @(posedge clk);  // E35
        #1;
        start = 1'b0;
        check({tag, " done one cycle"}, 64'(done), 64'd0);
        check({tag, " dbz one cycle"}, 64'(div_by_zero), 64'd0);
        check({tag, " idle after done"}, 64'(busy), 64'd0);
        check({tag, " hi held"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo held"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        srcA  = '0;
        srcB  = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply
        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1, 0, '0);
        run_op("mult -3x5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 0, 0, '0);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0, 0, '0);

        // Divide
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, 0, '0);
        run_op("divu 7/2", OP_DIVU, 32'h0000_0007, 32'h0000_0002,
               32'h0000_0001, 32'h0000_0003, 1'b0, 0, 0, 0, '0);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0, 0, 0, 0, '0);
        run_op("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 0, 0, '0);
        run_op("divu by 0", OP_DIVU, 32'h0000_1234, 32'h0000_0000,
               32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, '0);

        // Busy protection: start/hi_we/lo_we and operand changes mid-CALC
        run_op("mult busy prot", OP_MULT, 32'h0000_0005, 32'h0000_0007,
               32'h0000_0000, 32'h0000_0023, 1'b0, 1, 0, 0, '0);

        // mthi in IDLE
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
        check("mthi lo untouched", 64'(lo), 64'h0000_0000_0000_0023);

        // mthi + mtlo together
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h0000_0000_1234_5678);
        check("mthi+mtlo lo", 64'(lo), 64'h0000_0000_1234_5678);

        // start + lo_we in the same cycle: start wins
        run_op("multu start+lo_we", OP_MULTU, 32'h0000_0002, 32'h0000_0003,
               32'h0000_0000, 32'h0000_0006, 1'b0, 0, 0, 1, 32'h1234_5678);

        // Asynchronous reset during CALC iteration 10
        @(negedge clk);
        op    = OP_MULTU;
        srcA  = 32'hFFFF_FFFF;
        srcB  = 32'h0000_0003;
        start = 1'b1;
        @(posedge clk);  // E0
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        check("pre-reset busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset hi", 64'(hi), 64'd0);
        check("async reset lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        check("reset held busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu 6x7 after reset", OP_MULTU, 32'h0000_0006, 32'h0000_0007,
               32'h0000_0000, 32'h0000_002A, 1'b0, 0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
